// File: rtl/cache_controller_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// bus widths, address field positions and the controller state encoding.
package cache_controller_pkg;

  localparam int ADDRESS_LEN  = 32;
  localparam int REGISTER_LEN = 32;

  localparam int DEFAULT_SETS      = 64;
  localparam int DEFAULT_TAG_WIDTH = 10;

  // Byte address layout: [1:0] byte, [2] word in block, then index, then tag.
  localparam int WORD_SEL_BIT = 2;
  localparam int INDEX_LSB    = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL_W0 = 2'd1,
    FILL_W1 = 2'd2,
    WRITE   = 2'd3
  } cache_state_e;

  // Address of one word of the two-word block containing addr.
  function automatic logic [ADDRESS_LEN-1:0] block_word_addr(
    input logic [ADDRESS_LEN-1:INDEX_LSB] block,
    input logic                           word_sel
  );
    return {block, word_sel, 2'b00};
  endfunction

endpackage

// File: rtl/cache_controller_cache_memory.sv
// Tag, valid and two-word data arrays for the cache: asynchronous read,
// synchronous write, valid bits cleared asynchronously by reset.
module cache_memory
  import cache_controller_pkg::*;
#(
  parameter  int SETS        = DEFAULT_SETS,
  parameter  int TAG_WIDTH   = DEFAULT_TAG_WIDTH,
  localparam int INDEX_WIDTH = $clog2(SETS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INDEX_WIDTH-1:0]  rd_index,
  output logic                    rd_valid,
  output logic [TAG_WIDTH-1:0]    rd_tag,
  output logic [REGISTER_LEN-1:0] rd_word0,
  output logic [REGISTER_LEN-1:0] rd_word1,
  input  logic                    line_we,
  input  logic                    word_we,
  input  logic [INDEX_WIDTH-1:0]  wr_index,
  input  logic [TAG_WIDTH-1:0]    wr_tag,
  input  logic [REGISTER_LEN-1:0] wr_word0,
  input  logic [REGISTER_LEN-1:0] wr_word1,
  input  logic                    wr_word_sel,
  input  logic [REGISTER_LEN-1:0] wr_word_data
);

  logic [SETS-1:0]         valid_q;
  logic [TAG_WIDTH-1:0]    tag_q   [SETS];
  logic [REGISTER_LEN-1:0] word0_q [SETS];
  logic [REGISTER_LEN-1:0] word1_q [SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (line_we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Payload arrays need no reset: a line is only visible once its valid bit is set.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[wr_index]   <= wr_tag;
      word0_q[wr_index] <= wr_word0;
      word1_q[wr_index] <= wr_word1;
    end else if (word_we) begin
      if (wr_word_sel) begin
        word1_q[wr_index] <= wr_word_data;
      end else begin
        word0_q[wr_index] <= wr_word_data;
      end
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_word0 = word0_q[rd_index];
  assign rd_word1 = word1_q[rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// memory pipeline stage and the SRAM controller; two-word blocks.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int SETS      = DEFAULT_SETS,
  parameter int TAG_WIDTH = DEFAULT_TAG_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    write_enable,
  input  logic                    read_enable,
  input  logic [ADDRESS_LEN-1:0]  address,
  input  logic [REGISTER_LEN-1:0] write_data,
  output logic [REGISTER_LEN-1:0] read_data,
  output logic                    ready,
  output logic                    sram_write_enable,
  output logic                    sram_read_enable,
  output logic [ADDRESS_LEN-1:0]  sram_address,
  output logic [REGISTER_LEN-1:0] sram_write_data,
  input  logic [REGISTER_LEN-1:0] sram_read_data,
  input  logic                    sram_ready,
  output cache_state_e            debug_state
);

  localparam int INDEX_WIDTH = $clog2(SETS);
  localparam int TAG_LSB     = INDEX_LSB + INDEX_WIDTH;

  // SRAM handshake: a request (enable, sram_address, sram_write_data) is held
  // constant until a cycle where enable=1 and sram_ready=1; that cycle is the
  // transfer, and sram_read_data is only sampled in it.

  cache_state_e state_q, state_d;

  logic [ADDRESS_LEN-1:0]  req_addr_q;
  logic [REGISTER_LEN-1:0] req_wdata_q;
  logic [REGISTER_LEN-1:0] line_w0_q;

  logic [ADDRESS_LEN-1:0]  lookup_addr;
  logic [INDEX_WIDTH-1:0]  lookup_index;
  logic [TAG_WIDTH-1:0]    lookup_tag;
  logic                    lookup_word;
  logic                    unused_lookup_bits;

  logic                    rd_valid;
  logic [TAG_WIDTH-1:0]    rd_tag;
  logic [REGISTER_LEN-1:0] rd_word0;
  logic [REGISTER_LEN-1:0] rd_word1;
  logic                    hit;
  logic                    line_we;
  logic                    word_we;
  logic                    idle_read;
  logic                    idle_start;

  // Outside IDLE the request is taken from the copy latched at IDLE exit.
  assign lookup_addr        = (state_q == IDLE) ? address : req_addr_q;
  assign lookup_index       = lookup_addr[INDEX_LSB +: INDEX_WIDTH];
  assign lookup_tag         = lookup_addr[TAG_LSB +: TAG_WIDTH];
  assign lookup_word        = lookup_addr[WORD_SEL_BIT];
  assign unused_lookup_bits = ^lookup_addr;

  assign hit        = rd_valid && (rd_tag == lookup_tag);
  assign idle_read  = read_enable && !write_enable;
  assign idle_start = write_enable || read_enable;

  cache_memory #(
    .SETS      (SETS),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_cache_memory (
    .clk          (clk),
    .rst          (rst),
    .rd_index     (lookup_index),
    .rd_valid     (rd_valid),
    .rd_tag       (rd_tag),
    .rd_word0     (rd_word0),
    .rd_word1     (rd_word1),
    .line_we      (line_we),
    .word_we      (word_we),
    .wr_index     (lookup_index),
    .wr_tag       (lookup_tag),
    .wr_word0     (line_w0_q),
    .wr_word1     (sram_read_data),
    .wr_word_sel  (lookup_word),
    .wr_word_data (req_wdata_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (write_enable) begin
          state_d = WRITE;
        end else if (read_enable && !hit) begin
          state_d = FILL_W0;
        end
      end
      FILL_W0: if (sram_ready) state_d = FILL_W1;
      FILL_W1: if (sram_ready) state_d = IDLE;
      WRITE:   if (sram_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      line_w0_q   <= '0;
    end else begin
      if (state_q == IDLE && idle_start) begin
        req_addr_q  <= address;
        req_wdata_q <= write_data;
      end
      if (state_q == FILL_W0 && sram_ready) begin
        line_w0_q <= sram_read_data;
      end
    end
  end

  always_comb begin
    ready             = 1'b0;
    read_data         = '0;
    sram_read_enable  = 1'b0;
    sram_write_enable = 1'b0;
    sram_address      = '0;
    sram_write_data   = '0;
    line_we           = 1'b0;
    word_we           = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = !(write_enable || (read_enable && !hit));
        if (idle_read && hit) begin
          read_data = lookup_word ? rd_word1 : rd_word0;
        end
      end
      FILL_W0: begin
        sram_read_enable = 1'b1;
        sram_address     = block_word_addr(req_addr_q[ADDRESS_LEN-1:INDEX_LSB], 1'b0);
      end
      FILL_W1: begin
        sram_read_enable = 1'b1;
        sram_address     = block_word_addr(req_addr_q[ADDRESS_LEN-1:INDEX_LSB], 1'b1);
        if (sram_ready) begin
          ready     = 1'b1;
          line_we   = 1'b1;
          read_data = lookup_word ? sram_read_data : line_w0_q;
        end
      end
      WRITE: begin
        sram_write_enable = 1'b1;
        sram_address      = req_addr_q;
        sram_write_data   = req_wdata_q;
        if (sram_ready) begin
          ready   = 1'b1;
          word_we = hit;
        end
      end
      default: ready = 1'b0;
    endcase
    // Reset is honoured combinationally so the pipeline sees idle immediately.
    if (!rst) begin
      ready             = 1'b1;
      read_data         = '0;
      sram_read_enable  = 1'b0;
      sram_write_enable = 1'b0;
      sram_address      = '0;
      sram_write_data   = '0;
      line_we           = 1'b0;
      word_we           = 1'b0;
    end
  end

  assign debug_state = state_q;

endmodule
